ic_fill_ctrl: RTL and testbench

Instruction-cache line refill engine. Accepts one miss at a time from the cache controller and fetches the four 16-bit words of the line from backing memory, critical word first. It forwards the critical word to the fetch path, then drives the data RAM fill port and the tag RAM write port with the completed line. It produces exactly what the data RAM fill interface consumes: a 64-bit line plus way and line index, with a one-cycle write enable.

---
 rtl/ic_fill_ctrl.sv | 115 +++++++++++
 tb/tb_ic_fill_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ic_fill_ctrl.sv
// I-cache line refill engine: fetches a 4x16-bit line critical-word-first,
// forwards the critical word, then writes data and tag RAMs in one strobe.
module ic_fill_ctrl #(
    parameter int ADDR_W = 24,
    parameter int LINE_W = 8,
    parameter int WAY_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       miss_valid,
    output logic                       miss_ready,
    input  logic [ADDR_W-1:0]          miss_addr,
    input  logic [WAY_W-1:0]           miss_way,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [ADDR_W-1:0]          mem_req_addr,
    input  logic                       mem_rsp_valid,
    input  logic [15:0]                mem_rsp_data,
    output logic                       crit_valid,
    output logic [15:0]                crit_data,
    output logic                       fill_en,
    output logic [LINE_W-1:0]          fill_line,
    output logic [WAY_W-1:0]           fill_way,
    output logic [63:0]                fill_data,
    output logic                       tag_wr_en,
    output logic [ADDR_W-LINE_W-3:0]   tag_wr_tag,
    output logic                       busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

    typedef struct packed {
        logic [ADDR_W-3:0] base;
        logic [1:0]        w0;
        logic [WAY_W-1:0]  way;
    } miss_t;

    state_t            state, state_nxt;
    miss_t             miss_q;
    logic [2:0]        iss_cnt, rsp_cnt;
    logic [3:0][15:0]  line_q, line_nxt;
    logic              req_fire, rsp_fire, last_rsp;
    logic [1:0]        rsp_slot;

    assign req_fire = mem_req_valid & mem_req_ready;
    // Responses outside REQ/WAIT or past the fourth are dropped.
    assign rsp_fire = mem_rsp_valid & ((state == REQ) | (state == WAIT)) & ~rsp_cnt[2];
    assign last_rsp = rsp_fire & (rsp_cnt == 3'd3);
    assign rsp_slot = miss_q.w0 + rsp_cnt[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (miss_valid) state_nxt = REQ;
            REQ:   if (req_fire && iss_cnt == 3'd3)
                       state_nxt = (rsp_cnt[2] || last_rsp) ? WRITE : WAIT;
            WAIT:  if (last_rsp) state_nxt = WRITE;
            WRITE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        miss_ready    = (state == IDLE);
        mem_req_valid = (state == REQ);
        busy          = (state != IDLE);
        fill_en       = (state == WRITE);
        tag_wr_en     = (state == WRITE);
        mem_req_addr  = {miss_q.base, miss_q.w0 + iss_cnt[1:0]};
    end

    always_comb begin
        line_nxt = line_q;
        if (rsp_fire) line_nxt[rsp_slot] = mem_rsp_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_q     <= '0;
            iss_cnt    <= '0;
            rsp_cnt    <= '0;
            line_q     <= '0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
            fill_line  <= '0;
            fill_way   <= '0;
            fill_data  <= '0;
            tag_wr_tag <= '0;
        end else begin
            if (state == IDLE && miss_valid) begin
                miss_q  <= {miss_addr[ADDR_W-1:2], miss_addr[1:0], miss_way};
                iss_cnt <= '0;
                rsp_cnt <= '0;
            end
            if (req_fire) iss_cnt <= iss_cnt + 3'd1;
            if (rsp_fire) begin
                rsp_cnt <= rsp_cnt + 3'd1;
                line_q  <= line_nxt;
            end
            crit_valid <= rsp_fire && (rsp_cnt == 3'd0);
            if (rsp_fire && rsp_cnt == 3'd0) crit_data <= mem_rsp_data;
            // Fill outputs are captured on entry to WRITE and held afterwards.
            if (state_nxt == WRITE) begin
                fill_data  <= line_nxt;
                fill_line  <= miss_q.base[LINE_W-1:0];
                fill_way   <= miss_q.way;
                tag_wr_tag <= miss_q.base[ADDR_W-3:LINE_W];
            end
        end
    end
endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Scoreboard bench for ic_fill_ctrl: a memory model answers requests, a
// negedge monitor pops expected requests/crit words/fills as they appear.
module tb_ic_fill_ctrl;
    localparam int ADDR_W = 24, LINE_W = 8, WAY_W = 2, TAG_W = ADDR_W - LINE_W - 2;

    typedef struct packed {
        logic [LINE_W-1:0] line;
        logic [WAY_W-1:0]  way;
        logic [TAG_W-1:0]  tag;
        logic [63:0]       data;
    } fill_t;

    logic clk = 0, rst_n = 0;
    logic miss_valid = 0, miss_ready;
    logic [ADDR_W-1:0] miss_addr = '0;
    logic [WAY_W-1:0] miss_way = '0;
    logic mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [15:0] mem_rsp_data, crit_data;
    logic crit_valid, fill_en, tag_wr_en, busy;
    logic [LINE_W-1:0] fill_line;
    logic [WAY_W-1:0] fill_way;
    logic [63:0] fill_data;
    logic [TAG_W-1:0] tag_wr_tag;

    int checks = 0, errors = 0, cyc = 0;
    int fill_cnt = 0, hs_cnt = 0, rsp_drv = 0, stall_n = 0, stall_ctr = 0;
    logic comb_mode = 0, ready_r = 0, rsp_v_r = 0, stalled = 0;
    logic [15:0] rsp_d_r = '0, key = '0;
    logic [ADDR_W-1:0] stall_addr;
    logic [ADDR_W-1:0] exp_req[$];
    logic [15:0] exp_crit[$], pend[$];
    fill_t exp_fill[$];
    fill_t last_fill;
    int fill_cyc_q[$];

    assign mem_req_ready = comb_mode ? 1'b1 : ready_r;
    assign mem_rsp_valid = comb_mode ? mem_req_valid : rsp_v_r;
    assign mem_rsp_data  = comb_mode ? (mem_req_addr[15:0] ^ key) : rsp_d_r;

    ic_fill_ctrl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .WAY_W(WAY_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr), .miss_way(miss_way),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .crit_valid(crit_valid), .crit_data(crit_data),
        .fill_en(fill_en), .fill_line(fill_line), .fill_way(fill_way), .fill_data(fill_data),
        .tag_wr_en(tag_wr_en), .tag_wr_tag(tag_wr_tag), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] memf(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ key;
    endfunction

    // Memory model and output monitor; a negedge with cyc=v lies in cycle v+1.
    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_v_r = 0; ready_r = 0; stalled = 0; stall_ctr = 0;
        end else begin
            if (crit_valid) begin
                checks++;
                if (exp_crit.size() == 0) begin
                    errors++; $display("FAIL crit_unexpected got=%h required=none", crit_data);
                end else begin
                    logic [15:0] e;
                    e = exp_crit.pop_front();
                    if (crit_data !== e) begin
                        errors++; $display("FAIL crit_data got=%h required=%h", crit_data, e);
                    end
                end
            end
            checks++;
            if (tag_wr_en !== fill_en) begin
                errors++; $display("FAIL tag_wr_en got=%b required=%b", tag_wr_en, fill_en);
            end
            if (fill_en) begin
                fill_t g;
                g = {fill_line, fill_way, tag_wr_tag, fill_data};
                last_fill = g;
                fill_cnt++;
                fill_cyc_q.push_back(cyc + 1);
                checks++;
                if (exp_fill.size() == 0) begin
                    errors++; $display("FAIL fill_unexpected got=%h required=none", g);
                end else begin
                    fill_t e;
                    e = exp_fill.pop_front();
                    if (g !== e) begin
                        errors++; $display("FAIL fill got=%h required=%h", g, e);
                    end
                end
            end
            if (pend.size() > 0) begin
                rsp_v_r = 1; rsp_d_r = pend.pop_front(); rsp_drv++;
            end else rsp_v_r = 0;
            if (mem_req_valid) begin
                if (stalled) begin
                    checks++;
                    if (mem_req_addr !== stall_addr) begin
                        errors++; $display("FAIL req_addr_stable got=%h required=%h", mem_req_addr, stall_addr);
                    end
                end
                if (stall_ctr < stall_n) begin
                    ready_r = 0; stall_ctr++; stalled = 1; stall_addr = mem_req_addr;
                end else begin
                    ready_r = 1; stall_ctr = 0; stalled = 0; hs_cnt++;
                    checks++;
                    if (exp_req.size() == 0) begin
                        errors++; $display("FAIL req_unexpected got=%h required=none", mem_req_addr);
                    end else begin
                        logic [ADDR_W-1:0] e;
                        e = exp_req.pop_front();
                        if (mem_req_addr !== e) begin
                            errors++; $display("FAIL req_addr got=%h required=%h", mem_req_addr, e);
                        end
                    end
                    if (!comb_mode) pend.push_back(memf(mem_req_addr));
                end
            end else begin
                ready_r = 0; stalled = 0;
            end
        end
    end

    // Presents a miss at a negedge where miss_ready is high; returns its accept cycle.
    task automatic do_miss(input logic [ADDR_W-1:0] a, input logic [WAY_W-1:0] w, output int acc);
        fill_t f;
        @(negedge clk);
        for (int i = 0; i < 50 && !miss_ready; i++) @(negedge clk);
        miss_valid = 1; miss_addr = a; miss_way = w;
        acc = cyc + 1;
        for (int i = 0; i < 4; i++) exp_req.push_back({a[ADDR_W-1:2], 2'(a[1:0] + i)});
        exp_crit.push_back(memf(a));
        f.line = a[LINE_W+1:2]; f.way = w; f.tag = a[ADDR_W-1:LINE_W+2];
        for (int k = 0; k < 4; k++) f.data[16*k +: 16] = memf({a[ADDR_W-1:2], 2'(k)});
        exp_fill.push_back(f);
        @(negedge clk);
        miss_valid = 0;
    endtask

    task automatic wait_fill(input int target, input string name);
        int n;
        n = 0;
        while (fill_cnt < target && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (fill_cnt < target) begin
            errors++; $display("FAIL %s_timeout got=%0d fills required=%0d", name, fill_cnt, target);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 7;
        if (miss_ready !== 1'b1) begin errors++; $display("FAIL rst_miss_ready got=%b required=1", miss_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b required=0", busy); end
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b required=0", mem_req_valid); end
        if (crit_valid !== 1'b0) begin errors++; $display("FAIL rst_crit_valid got=%b required=0", crit_valid); end
        if (fill_en !== 1'b0) begin errors++; $display("FAIL rst_fill_en got=%b required=0", fill_en); end
        if (fill_data !== 64'h0) begin errors++; $display("FAIL rst_fill_data got=%h required=0", fill_data); end
        if (mem_req_addr !== '0) begin errors++; $display("FAIL rst_req_addr got=%h required=0", mem_req_addr); end
        #2 rst_n = 1;
    endtask

    task automatic test_aligned();
        int acc;
        key = 16'h01A4; comb_mode = 0; stall_n = 0;
        do_miss(24'h000104, 2'd1, acc);
        wait_fill(fill_cnt + 1, "aligned");
        checks += 3;
        if (last_fill.data !== 64'h00A3_00A2_00A1_00A0) begin
            errors++; $display("FAIL aligned_data got=%h required=00a300a200a100a0", last_fill.data);
        end
        if (last_fill.line !== 8'h41) begin errors++; $display("FAIL aligned_line got=%h required=41", last_fill.line); end
        if (last_fill.tag !== 14'h0) begin errors++; $display("FAIL aligned_tag got=%h required=0", last_fill.tag); end
    endtask

    task automatic test_wrapped();
        int acc;
        key = 16'h5A5A;
        do_miss(24'h123456, 2'd2, acc);
        wait_fill(fill_cnt + 1, "wrapped");
        checks += 2;
        if (last_fill.line !== 8'h15) begin errors++; $display("FAIL wrapped_line got=%h required=15", last_fill.line); end
        if (last_fill.tag !== 14'h048D) begin errors++; $display("FAIL wrapped_tag got=%h required=048d", last_fill.tag); end
    endtask

    task automatic test_backpressure();
        int acc, hs0, f0;
        key = 16'h3C3C; stall_n = 3;
        hs0 = hs_cnt; f0 = fill_cnt;
        do_miss(24'h00ABC7, 2'd3, acc);
        wait_fill(f0 + 1, "backpressure");
        repeat (6) @(negedge clk);
        checks += 2;
        if (hs_cnt - hs0 !== 4) begin errors++; $display("FAIL bp_handshakes got=%0d required=4", hs_cnt - hs0); end
        if (fill_cnt - f0 !== 1) begin errors++; $display("FAIL bp_fill_count got=%0d required=1", fill_cnt - f0); end
        stall_n = 0;
    endtask

    task automatic test_zero_wait();
        int acc1, acc2, f0;
        fill_t f;
        key = 16'h0F0F; comb_mode = 1; stall_n = 0;
        fill_cyc_q.delete();
        f0 = fill_cnt;
        do_miss(24'h0456F1, 2'd0, acc1);
        // miss_valid held high with the next miss: accept must land exactly at C+6
        miss_valid = 1; miss_addr = 24'h0777F2; miss_way = 2'd2;
        acc2 = -1;
        for (int i = 0; i < 20 && acc2 < 0; i++) begin
            if (miss_ready) acc2 = cyc + 1;
            else @(negedge clk);
        end
        checks++;
        if (acc2 !== acc1 + 6) begin errors++; $display("FAIL zw_second_accept got=%0d required=%0d", acc2, acc1 + 6); end
        for (int i = 0; i < 4; i++) exp_req.push_back({miss_addr[ADDR_W-1:2], 2'(miss_addr[1:0] + i)});
        exp_crit.push_back(memf(miss_addr));
        f.line = miss_addr[LINE_W+1:2]; f.way = miss_way; f.tag = miss_addr[ADDR_W-1:LINE_W+2];
        for (int k = 0; k < 4; k++) f.data[16*k +: 16] = memf({miss_addr[ADDR_W-1:2], 2'(k)});
        exp_fill.push_back(f);
        @(negedge clk);
        miss_valid = 0;
        wait_fill(f0 + 2, "zero_wait");
        checks += 2;
        if (fill_cyc_q.size() < 2) begin
            errors++; $display("FAIL zw_fill_cycles got=%0d fills required=2", fill_cyc_q.size());
        end else begin
            if (fill_cyc_q[0] !== acc1 + 5) begin errors++; $display("FAIL zw_fill1_cycle got=%0d required=%0d", fill_cyc_q[0], acc1 + 5); end
            if (fill_cyc_q[1] !== acc2 + 5) begin errors++; $display("FAIL zw_fill2_cycle got=%0d required=%0d", fill_cyc_q[1], acc2 + 5); end
        end
        comb_mode = 0;
    endtask

    task automatic test_reset_mid_fill();
        int acc, r0, f0, n;
        key = 16'h7E11; stall_n = 3;
        r0 = rsp_drv; f0 = fill_cnt;
        do_miss(24'h0012A9, 2'd1, acc);
        n = 0;
        while (rsp_drv < r0 + 2 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (rsp_drv < r0 + 2) begin errors++; $display("FAIL rmf_timeout got=%0d rsps required=2", rsp_drv - r0); end
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy got=%b required=0", busy); end
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rmf_req_valid got=%b required=0", mem_req_valid); end
        if (miss_ready !== 1'b1) begin errors++; $display("FAIL rmf_miss_ready got=%b required=1", miss_ready); end
        if (fill_en !== 1'b0) begin errors++; $display("FAIL rmf_fill_en got=%b required=0", fill_en); end
        if (crit_data !== 16'h0) begin errors++; $display("FAIL rmf_crit_data got=%h required=0", crit_data); end
        exp_req.delete(); exp_crit.delete(); exp_fill.delete(); pend.delete();
        stall_n = 0;
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        pend.push_back(16'hDEAD);
        repeat (6) @(negedge clk);
        checks += 3;
        if (fill_cnt !== f0) begin errors++; $display("FAIL rmf_no_fill got=%0d required=%0d", fill_cnt, f0); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rmf_stray_busy got=%b required=0", busy); end
        if (miss_ready !== 1'b1) begin errors++; $display("FAIL rmf_stray_ready got=%b required=1", miss_ready); end
    endtask

    task automatic test_spurious();
        int f0;
        f0 = fill_cnt;
        @(negedge clk);
        pend.push_back(16'h1234);
        pend.push_back(16'h5678);
        repeat (5) @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL spur_busy got=%b required=0", busy); end
        if (fill_cnt !== f0) begin errors++; $display("FAIL spur_fill got=%0d required=%0d", fill_cnt, f0); end
    endtask

    task automatic test_back_to_back_after_spurious();
        int acc;
        key = 16'hC001;
        do_miss(24'h0FFFFE, 2'd3, acc);
        wait_fill(fill_cnt + 1, "after_spurious");
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_wrapped();
        test_backpressure();
        test_zero_wait();
        test_reset_mid_fill();
        test_spurious();
        test_back_to_back_after_spurious();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_req.size() + exp_crit.size() + exp_fill.size() != 0) begin
            errors++;
            $display("FAIL leftover got=%0d/%0d/%0d required=0/0/0", exp_req.size(), exp_crit.size(), exp_fill.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
